// File: rtl/ow_session_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ow_session_arbiter
// Function : round-robin session arbiter sharing one one-wire command
//            controller between NREQ requesters, with a per-command watchdog
// Revision : 1.0
// ============================================================================
module ow_session_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 48000000,
    parameter int unsigned TW      = 26
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req,
    output logic [NREQ-1:0]   o_gnt,
    input  logic [6*NREQ-1:0] i_cmd,
    input  logic [NREQ-1:0]   i_cmd_vld,
    output logic [NREQ-1:0]   o_cmd_rdy,
    output logic [NREQ-1:0]   o_done,
    output logic              o_detect,
    output logic [15:0]       o_data,
    output logic              o_timeout,
    output logic [5:0]        o_ow_command,
    output logic              o_ow_enable,
    input  logic              i_ow_busy,
    input  logic              i_ow_irq,
    input  logic              i_ow_detect,
    input  logic [15:0]       i_ow_data
);

    localparam int unsigned     IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TW-1:0]   C_TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0]   C_LAST_IDX = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] C_ONE      = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANTED = 2'd1,
        S_WAIT    = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [IW-1:0]   own_q, own_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [5:0]      cmd_q, cmd_d;
    logic            en_q, en_d;
    logic            detect_q, detect_d;
    logic            timeout_q, timeout_d;
    logic [15:0]     data_q, data_d;

    logic            w_found;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_pick;
    logic [5:0]      w_own_cmd;
    logic            w_own_req;
    logic            w_own_vld;
    logic            w_release;

    // Scan upward from the last owner + 1 so the previous owner gets lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_pick  = ptr_q;
        w_idx   = ptr_q;
        for (int k = 0; k < int'(NREQ); k++) begin
            w_idx = (w_idx == C_LAST_IDX) ? '0 : w_idx + IW'(1);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_own_cmd = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (own_q == IW'(k)) begin
                w_own_cmd = i_cmd[6*k +: 6];
            end
        end
    end

    assign w_own_req = |(gnt_q & i_req);
    assign w_own_vld = |(gnt_q & i_cmd_vld);
    assign o_cmd_rdy = ((state_q == S_GRANTED) && !i_ow_busy) ? (gnt_q & i_req) : '0;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        own_d     = own_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        cmd_d     = '0;
        en_d      = 1'b0;
        done_d    = '0;
        detect_d  = detect_q;
        data_d    = data_q;
        timeout_d = timeout_q;
        w_release = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    gnt_d   = C_ONE << w_pick;
                    own_d   = w_pick;
                    state_d = S_GRANTED;
                end
            end
            S_GRANTED: begin
                if (!w_own_req) begin
                    w_release = 1'b1;
                end else if (w_own_vld && !i_ow_busy) begin
                    if (w_own_cmd == 6'd0) begin
                        done_d = gnt_q;
                    end else begin
                        cmd_d   = w_own_cmd;
                        en_d    = 1'b1;
                        timer_d = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // A same-cycle irq beats the watchdog.
                if (i_ow_irq) begin
                    done_d    = gnt_q;
                    detect_d  = i_ow_detect;
                    data_d    = i_ow_data;
                    timeout_d = 1'b0;
                    if (w_own_req) begin
                        state_d = S_GRANTED;
                    end else begin
                        w_release = 1'b1;
                    end
                end else if (timer_q == C_TMO_LAST) begin
                    done_d    = gnt_q;
                    timeout_d = 1'b1;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!i_ow_busy) begin
                    if (w_own_req) begin
                        state_d = S_GRANTED;
                    end else begin
                        w_release = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_release) begin
            gnt_d   = '0;
            ptr_d   = own_q;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            own_q     <= '0;
            ptr_q     <= C_LAST_IDX;
            timer_q   <= '0;
            cmd_q     <= '0;
            en_q      <= 1'b0;
            done_q    <= '0;
            detect_q  <= 1'b0;
            data_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            own_q     <= own_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            cmd_q     <= cmd_d;
            en_q      <= en_d;
            done_q    <= done_d;
            detect_q  <= detect_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_gnt        = gnt_q;
    assign o_done       = done_q;
    assign o_detect     = detect_q;
    assign o_data       = data_q;
    assign o_timeout    = timeout_q;
    assign o_ow_command = cmd_q;
    assign o_ow_enable  = en_q;

endmodule
`default_nettype wire

// File: tb/tb_ow_session_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ow_session_arbiter
// Function : directed scenarios plus randomized sessions against a reference model
// Revision : 1.0
// ============================================================================
module tb_ow_session_arbiter;

    localparam int NREQ = 2;
    localparam int TMO  = 100;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req   = '0;
    logic [1:0]  vld   = '0;
    logic [11:0] cmd   = '0;
    logic        busy  = 1'b0;
    logic        irq   = 1'b0;
    logic        det   = 1'b0;
    logic [15:0] dat   = '0;

    logic [1:0]  gnt, rdy, done;
    logic        o_det, o_to, ow_en;
    logic [15:0] o_dat;
    logic [5:0]  ow_cmd;

    int n_chk  = 0;
    int n_fail = 0;

    ow_session_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO), .TW(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .o_gnt        (gnt),
        .i_cmd        (cmd),
        .i_cmd_vld    (vld),
        .o_cmd_rdy    (rdy),
        .o_done       (done),
        .o_detect     (o_det),
        .o_data       (o_dat),
        .o_timeout    (o_to),
        .o_ow_command (ow_cmd),
        .o_ow_enable  (ow_en),
        .i_ow_busy    (busy),
        .i_ow_irq     (irq),
        .i_ow_detect  (det),
        .i_ow_data    (dat)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; vld = '0; cmd = '0; busy = 1'b0; irq = 1'b0; det = 1'b0; dat = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 2'b11;
        repeat (2) @(negedge clk);
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        n_chk++; if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b want 00", done); end
        n_chk++; if ({ow_en, ow_cmd} !== 7'd0) begin n_fail++; $display("FAIL reset_ow: got en=%b cmd=%h want 0", ow_en, ow_cmd); end
        n_chk++; if ({o_det, o_dat, o_to} !== 18'd0) begin n_fail++; $display("FAIL reset_result: got det=%b data=%h to=%b want 0", o_det, o_dat, o_to); end
        n_chk++; if (rdy !== 2'b00) begin n_fail++; $display("FAIL reset_rdy: got %b want 00", rdy); end
        req = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_idle_gnt: got %b want 00", gnt); end
    endtask

    task automatic test_single_session();
        do_reset();
        req = 2'b01;
        @(negedge clk);
        n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b want 01", gnt); end
        #1;
        n_chk++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL single_rdy: got %b want 01", rdy); end
        vld = 2'b01; cmd[5:0] = 6'd1;
        @(negedge clk);
        n_chk++; if (ow_en !== 1'b1 || ow_cmd !== 6'd1) begin n_fail++; $display("FAIL single_fwd1: got en=%b cmd=%0d want en=1 cmd=1", ow_en, ow_cmd); end
        vld = 2'b00; busy = 1'b1;
        @(negedge clk);
        n_chk++; if (ow_en !== 1'b0 || ow_cmd !== 6'd0) begin n_fail++; $display("FAIL single_en_pulse: got en=%b cmd=%0d want 0", ow_en, ow_cmd); end
        repeat (3) @(negedge clk);
        irq = 1'b1; det = 1'b1; dat = 16'h0000; busy = 1'b0;
        @(negedge clk);
        irq = 1'b0;
        n_chk++; if (done !== 2'b01 || o_det !== 1'b1 || o_to !== 1'b0 || o_dat !== 16'h0000) begin
            n_fail++; $display("FAIL single_done1: got done=%b det=%b to=%b data=%h want 01 1 0 0000", done, o_det, o_to, o_dat);
        end
        @(negedge clk);
        n_chk++; if (done !== 2'b00 || gnt !== 2'b01) begin n_fail++; $display("FAIL single_after1: got done=%b gnt=%b want 00 01", done, gnt); end
        vld = 2'b01; cmd[5:0] = 6'd5;
        @(negedge clk);
        n_chk++; if (ow_en !== 1'b1 || ow_cmd !== 6'd5) begin n_fail++; $display("FAIL single_fwd5: got en=%b cmd=%0d want en=1 cmd=5", ow_en, ow_cmd); end
        vld = 2'b00; busy = 1'b1;
        repeat (2) @(negedge clk);
        irq = 1'b1; dat = 16'h0191; busy = 1'b0;
        @(negedge clk);
        irq = 1'b0;
        n_chk++; if (done !== 2'b01 || o_dat !== 16'h0191) begin n_fail++; $display("FAIL single_done5: got done=%b data=%h want 01 0191", done, o_dat); end
        @(negedge clk);
        vld = 2'b01; cmd[5:0] = 6'd0;
        @(negedge clk);
        vld = 2'b00;
        n_chk++; if (done !== 2'b01 || ow_en !== 1'b0 || o_dat !== 16'h0191 || o_det !== 1'b1) begin
            n_fail++; $display("FAIL single_cmd0: got done=%b en=%b data=%h det=%b want 01 0 0191 1", done, ow_en, o_dat, o_det);
        end
        req = 2'b00;
        @(negedge clk);
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b want 00", gnt); end
    endtask

    task automatic test_contention();
        do_reset();
        req = 2'b11;
        @(negedge clk);
        n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL cont_first: got %b want 01", gnt); end
        req = 2'b10;
        @(negedge clk);
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL cont_gap: got %b want 00", gnt); end
        @(negedge clk);
        n_chk++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL cont_second: got %b want 10", gnt); end
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL cont_hold: got %b want 10", gnt); end
        end
        req = 2'b01;
        @(negedge clk);
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL cont_gap2: got %b want 00", gnt); end
        @(negedge clk);
        n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL cont_back: got %b want 01", gnt); end
        req = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nonowner();
        do_reset();
        req = 2'b01;
        @(negedge clk);
        vld = 2'b10; cmd[11:6] = 6'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++; if (rdy[1] !== 1'b0) begin n_fail++; $display("FAIL nonowner_rdy: got %b want 0", rdy[1]); end
            @(negedge clk);
            n_chk++; if (ow_en !== 1'b0 || done !== 2'b00) begin n_fail++; $display("FAIL nonowner_fwd: got en=%b done=%b want 0 00", ow_en, done); end
        end
        vld = 2'b00; req = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        req = 2'b01;
        @(negedge clk);
        vld = 2'b01; cmd[5:0] = 6'd1;
        @(negedge clk);
        vld = 2'b00; busy = 1'b1;
        @(negedge clk);
        irq = 1'b1; det = 1'b1; dat = 16'hBEEF; busy = 1'b0;
        @(negedge clk);
        irq = 1'b0;
        n_chk++; if (o_dat !== 16'hBEEF) begin n_fail++; $display("FAIL tmo_setup: got %h want beef", o_dat); end
        vld = 2'b01; cmd[5:0] = 6'd2;
        @(negedge clk);
        n_chk++; if (ow_en !== 1'b1) begin n_fail++; $display("FAIL tmo_en: got %b want 1", ow_en); end
        vld = 2'b00; busy = 1'b1;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done !== 2'b00) begin n = i; break; end
        end
        n_chk++; if (n != TMO) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", n, TMO); end
        n_chk++; if (done !== 2'b01 || o_to !== 1'b1 || o_dat !== 16'hBEEF || o_det !== 1'b1) begin
            n_fail++; $display("FAIL tmo_result: got done=%b to=%b data=%h det=%b want 01 1 beef 1", done, o_to, o_dat, o_det);
        end
        vld = 2'b01; cmd[5:0] = 6'd3;
        for (int i = 0; i < 20; i++) begin
            irq = (i == 10);
            #1;
            n_chk++; if (rdy !== 2'b00) begin n_fail++; $display("FAIL tmo_drain_rdy: got %b want 00", rdy); end
            @(negedge clk);
            n_chk++; if (ow_en !== 1'b0 || done !== 2'b00) begin n_fail++; $display("FAIL tmo_drain_quiet: got en=%b done=%b want 0 00", ow_en, done); end
        end
        irq = 1'b0; vld = 2'b00; busy = 1'b0;
        #1;
        n_chk++; if (rdy !== 2'b00) begin n_fail++; $display("FAIL tmo_busy_fall_rdy: got %b want 00", rdy); end
        @(negedge clk);
        #1;
        n_chk++; if (rdy !== 2'b01 || o_to !== 1'b1) begin n_fail++; $display("FAIL tmo_regrant: got rdy=%b to=%b want 01 1", rdy, o_to); end
        vld = 2'b01; cmd[5:0] = 6'd1;
        @(negedge clk);
        vld = 2'b00;
        irq = 1'b1; det = 1'b0; dat = 16'h1234;
        @(negedge clk);
        irq = 1'b0;
        n_chk++; if (done !== 2'b01 || o_to !== 1'b0 || o_dat !== 16'h1234 || o_det !== 1'b0) begin
            n_fail++; $display("FAIL tmo_clear: got done=%b to=%b data=%h det=%b want 01 0 1234 0", done, o_to, o_dat, o_det);
        end
        req = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_collision();
        do_reset();
        req = 2'b01;
        @(negedge clk);
        busy = 1'b1; vld = 2'b01; cmd[5:0] = 6'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (rdy !== 2'b00) begin n_fail++; $display("FAIL busy_rdy: got %b want 00", rdy); end
            @(negedge clk);
            n_chk++; if (ow_en !== 1'b0) begin n_fail++; $display("FAIL busy_en: got %b want 0", ow_en); end
        end
        busy = 1'b0;
        #1;
        n_chk++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL busy_fall_rdy: got %b want 01", rdy); end
        @(negedge clk);
        n_chk++; if (ow_en !== 1'b1 || ow_cmd !== 6'd4) begin n_fail++; $display("FAIL busy_fwd: got en=%b cmd=%0d want 1 4", ow_en, ow_cmd); end
        vld = 2'b00; busy = 1'b1;
        @(negedge clk);
        irq = 1'b1; busy = 1'b0; dat = 16'h55AA;
        @(negedge clk);
        irq = 1'b0;
        n_chk++; if (done !== 2'b01 || o_dat !== 16'h55AA) begin n_fail++; $display("FAIL busy_done: got done=%b data=%h want 01 55aa", done, o_dat); end
        req = 2'b00; vld = 2'b01; cmd[5:0] = 6'd3;
        #1;
        n_chk++; if (rdy !== 2'b00) begin n_fail++; $display("FAIL drop_rdy: got %b want 00", rdy); end
        @(negedge clk);
        n_chk++; if (gnt !== 2'b00 || ow_en !== 1'b0) begin n_fail++; $display("FAIL drop_release: got gnt=%b en=%b want 00 0", gnt, ow_en); end
        vld = 2'b00;
        @(negedge clk);
        n_chk++; if (ow_en !== 1'b0 || done !== 2'b00) begin n_fail++; $display("FAIL drop_quiet: got en=%b done=%b want 0 00", ow_en, done); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        req = 2'b01;
        @(negedge clk);
        vld = 2'b01; cmd[5:0] = 6'd1;
        @(negedge clk);
        vld = 2'b00; irq = 1'b1; det = 1'b1; dat = 16'hA5A5;
        @(negedge clk);
        irq = 1'b0;
        n_chk++; if (o_dat !== 16'hA5A5) begin n_fail++; $display("FAIL midrst_setup: got %h want a5a5", o_dat); end
        vld = 2'b01; cmd[5:0] = 6'd2;
        @(negedge clk);
        vld = 2'b00; busy = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (gnt !== 2'b00 || done !== 2'b00) begin n_fail++; $display("FAIL midrst_gnt: got gnt=%b done=%b want 00 00", gnt, done); end
        n_chk++; if ({ow_en, ow_cmd, o_det, o_dat, o_to} !== 25'd0) begin
            n_fail++; $display("FAIL midrst_outs: got en=%b cmd=%h det=%b data=%h to=%b want 0", ow_en, ow_cmd, o_det, o_dat, o_to);
        end
        @(negedge clk);
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        n_chk++; if (done !== 2'b00) begin n_fail++; $display("FAIL midrst_nodone: got %b want 00", done); end
        busy = 1'b0; rst_n = 1'b1; req = 2'b10;
        @(negedge clk);
        n_chk++; if (gnt !== 2'b10 || done !== 2'b00) begin n_fail++; $display("FAIL midrst_regrant: got gnt=%b done=%b want 10 00", gnt, done); end
        req = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    // Random sessions; the model tracks session owner, outstanding command and
    // its issue time, and predicts each cycle's outputs from the rules.
    task automatic test_random();
        int          m_phase, m_owner, m_last, m_en_cyc, pick, j, mk_mode, mk_left;
        bit          close_s, rel;
        logic [1:0]  e_gnt, e_done, e_rdy;
        logic        e_en, e_det, e_to;
        logic [5:0]  e_cmd, c;
        logic [15:0] e_dat;
        do_reset();
        m_phase = 0; m_owner = 0; m_last = NREQ - 1; m_en_cyc = 0;
        e_gnt = '0; e_done = '0; e_en = 1'b0; e_cmd = '0; e_det = 1'b0; e_dat = '0; e_to = 1'b0;
        mk_mode = 0; mk_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            n_chk++; if (gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt @%0d: got %b want %b", cyc, gnt, e_gnt); end
            n_chk++; if (done !== e_done) begin n_fail++; $display("FAIL rnd_done @%0d: got %b want %b", cyc, done, e_done); end
            n_chk++; if (ow_en !== e_en || ow_cmd !== e_cmd) begin n_fail++; $display("FAIL rnd_fwd @%0d: got %b/%0d want %b/%0d", cyc, ow_en, ow_cmd, e_en, e_cmd); end
            n_chk++; if (o_det !== e_det || o_dat !== e_dat || o_to !== e_to) begin
                n_fail++; $display("FAIL rnd_result @%0d: got %b/%h/%b want %b/%h/%b", cyc, o_det, o_dat, o_to, e_det, e_dat, e_to);
            end
            // controller stand-in: answers after a short delay, or stays silent
            if (ow_en === 1'b1) begin
                if ($urandom_range(0, 9) == 0) begin
                    mk_mode = 2; mk_left = TMO + int'($urandom_range(0, 12));
                end else begin
                    mk_mode = 1; mk_left = int'($urandom_range(1, 12));
                end
            end
            irq = 1'b0;
            if (mk_mode != 0) begin
                mk_left--;
                if (mk_left == 0) begin
                    if (mk_mode == 1) begin
                        irq = 1'b1; det = 1'($urandom_range(0, 1)); dat = 16'($urandom);
                    end
                    mk_mode = 0;
                end
            end
            busy = (mk_mode != 0) || ($urandom_range(0, 7) == 0);
            for (int k = 0; k < NREQ; k++) begin
                if ($urandom_range(0, 15) == 0) req[k] = ~req[k];
                vld[k] = 1'($urandom_range(0, 1));
                cmd[6*k +: 6] = 6'($urandom_range(0, 6));
            end
            #1;
            e_rdy = (m_phase == 1 && req[m_owner] && !busy) ? 2'(1 << m_owner) : 2'b00;
            n_chk++; if (rdy !== e_rdy) begin n_fail++; $display("FAIL rnd_rdy @%0d: got %b want %b", cyc, rdy, e_rdy); end
            e_en = 1'b0; e_cmd = '0; e_done = '0; close_s = 1'b0; rel = 1'b0;
            case (m_phase)
                0: if (req != 2'b00) begin
                    pick = -1;
                    for (int s = 1; s <= NREQ; s++) begin
                        j = (m_last + s) % NREQ;
                        if (pick < 0 && req[j]) pick = j;
                    end
                    m_owner = pick; e_gnt = 2'(1 << pick); m_phase = 1;
                end
                1: if (!req[m_owner]) rel = 1'b1;
                   else if (vld[m_owner] && !busy) begin
                       c = cmd[6*m_owner +: 6];
                       if (c == 6'd0) e_done = 2'(1 << m_owner);
                       else begin e_en = 1'b1; e_cmd = c; m_phase = 2; m_en_cyc = cyc + 1; end
                   end
                2: if (irq) begin
                       e_done = 2'(1 << m_owner); e_det = det; e_dat = dat; e_to = 1'b0; close_s = 1'b1;
                   end else if (cyc - m_en_cyc == TMO - 1) begin
                       e_done = 2'(1 << m_owner); e_to = 1'b1; m_phase = 3;
                   end
                default: if (!busy) close_s = 1'b1;
            endcase
            if (close_s) begin
                if (req[m_owner]) m_phase = 1; else rel = 1'b1;
            end
            if (rel) begin
                e_gnt = 2'b00; m_last = m_owner; m_phase = 0;
            end
        end
        req = '0; vld = '0; busy = 1'b0; irq = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_session();
        test_contention();
        test_nonowner();
        test_timeout();
        test_busy_collision();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
